// File: rtl/ram_dma_engine.sv
// rtl/ram_dma_engine.sv - byte-wide RAM block copy / block fill bus master
//
// Purpose: takes a single start command and performs either a block copy
// (src -> dst, ascending, one byte per READ/WRITE pair) or a block fill
// (fill_val -> dst, one byte per cycle) of 0..2^AW bytes. The engine owns
// the RAM port while busy is high and pulses done for one cycle at the end.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   start     command strobe, sampled only in IDLE
//   mode      0 = copy, 1 = fill (captured with start)
//   src, dst  source / destination base addresses (captured with start)
//   len       byte count 0..2^AW (captured with start)
//   fill_val  fill pattern (captured with start)
//   busy      high in READ and WRITE
//   done      one-cycle completion pulse
//   mem_a     RAM address
//   mem_wd    RAM write data
//   mem_we    RAM write enable
//   mem_rd    RAM read data, combinational from mem_a
module ram_dma_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [AW-1:0] sp;
  logic [AW-1:0] dp;
  logic [AW:0]   cnt;
  logic [DW-1:0] data;
  logic          md;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      sp    <= '0;
      dp    <= '0;
      cnt   <= '0;
      data  <= '0;
      md    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sp  <= src;
            dp  <= dst;
            cnt <= len;
            md  <= mode;
            if (mode) begin
              data <= fill_val;
            end
            if (len == '0) begin
              state <= S_DONE;
            end else if (mode) begin
              state <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          // RAM read is combinational, so the byte is valid at this edge.
          data  <= mem_rd;
          sp    <= sp + PTR_ONE;
          state <= S_WRITE;
        end
        S_WRITE: begin
          dp  <= dp + PTR_ONE;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= S_DONE;
          end else if (md) begin
            state <= S_WRITE;
          end else begin
            state <= S_READ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM port is decoded purely from state so IDLE/DONE present a quiet bus.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    case (state)
      S_READ: begin
        mem_a = sp;
      end
      S_WRITE: begin
        mem_a  = dp;
        mem_wd = data;
        mem_we = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state == S_READ) || (state == S_WRITE);
  assign done = (state == S_DONE);

endmodule

// File: doc/ram_dma_engine.md
# ram_dma_engine

Bus-master engine that drives the byte-wide, 256-entry data RAM port: address, write data, write enable, and combinational read data. It performs block copy and block fill operations in place of the core. A single start command copies or fills up to 256 bytes. The engine returns `done` when finished. It sits between the core's control logic and the RAM, owning the RAM port while `busy` is high.

## Interface
- `AW`, 8, address width; RAM depth is 2^AW.
- `DW`, 8, data width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; captured with `start`.
- `src`  in  AW  copy source base address; captured with `start`.
- `dst`  in  AW  destination base address; captured with `start`.
- `len`  in  AW+1  byte count, 0..256; captured with `start`.
- `fill_val`  in  DW  fill pattern; captured with `start`.
- `busy`  out  1  high while in READ or WRITE.
- `done`  out  1  one-cycle completion pulse.
- `mem_a`  out  AW  RAM address.
- `mem_wd`  out  DW  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_rd`  in  DW  RAM read data, combinational from `mem_a`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Internal registers: `sp`/`dp` (AW bits), `cnt` (AW+1 bits), `data` (DW bits), `md` (1 bit).
- IDLE with `start=1`:
  - Capture `sp=src`, `dp=dst`, `cnt=len`, `md=mode`.
  - `data` = `fill_val` when mode=1.
  - `len=0`: go to DONE.
  - `len>0`, mode=0: go to READ.
  - `len>0`, mode=1: go to WRITE.
- READ:
  - Drive `mem_a=sp`, `mem_we=0`.
  - At the edge, latch `data<=mem_rd`, `sp<=sp+1`, go to WRITE.
- WRITE:
  - Drive `mem_a=dp`, `mem_wd=data`, `mem_we=1`.
  - At the edge, `dp<=dp+1`, `cnt<=cnt-1`.
  - If `cnt==1`: go to DONE.
  - Otherwise: copy goes to READ, fill stays in WRITE.
- DONE: `done=1` for exactly one cycle, then IDLE. `start` is ignored in DONE.
- `start` is ignored in READ, WRITE and DONE. It is not queued.
- Pointers wrap modulo 2^AW: 0xFF+1 = 0x00. `cnt` never wraps.
- Copy order is strictly ascending and byte-by-byte.
  - Overlap with `dst>src` propagates already-written bytes. This is defined behaviour; there is no backward copy.
  - `src==dst` rewrites identical values.
- IDLE and DONE outputs: `mem_a=0`, `mem_wd=0`, `mem_we=0`.
- `mem_we` is asserted only in WRITE.

## Timing
- Reset (`rst=0` at an edge):
  - State becomes IDLE; `sp`, `dp`, `cnt`, `data`, `md` are cleared.
  - `busy=0`, `done=0`, `mem_we=0`, `mem_a=0`, `mem_wd=0` from the following cycle.
  - Reset mid-transfer aborts immediately. No further writes occur. `done` is not pulsed.
- Let `start` be sampled at edge E0. Cycle k is the cycle after edge Ek-1.
- Copy of N bytes:
  - Reads in cycles 1, 3, …, 2N-1.
  - Writes in cycles 2, 4, …, 2N.
  - DONE in cycle 2N+1; IDLE from cycle 2N+2.
  - `busy` high in cycles 1..2N.
- Fill of N bytes:
  - Writes in cycles 1..N.
  - DONE in cycle N+1; `busy` high in cycles 1..N.
- `len=0`: DONE in cycle 1, no RAM access, `busy` never high.
- Throughput:
  - Copy: 2 cycles/byte; maximum 513 cycles from start to `done` inclusive.
  - Fill: 1 cycle/byte.
- Earliest next accepted `start` is the first IDLE cycle after DONE.
- RAM read is combinational, so `data` is valid at the READ edge. There is no wait state.

## Test plan
- Reset:
  - Preload RAM with the pattern.
  - Assert `rst=0` for 2 cycles.
  - Required: `busy=0`, `done=0`, `mem_we=0`, `mem_a=0`.
- Copy:
  - Preload `RAM[0x10..0x13]=A1,B2,C3,D4`.
  - Start `mode=0`, `src=0x10`, `dst=0x80`, `len=4`.
  - Required: `RAM[0x80..0x83]=A1,B2,C3,D4`.
  - Required: `done` in cycle 9, `busy` high for exactly 8 cycles.
- Fill with wrap:
  - Start `mode=1`, `dst=0xFE`, `len=4`, `fill_val=0x5A`.
  - Required: `RAM[0xFE]`, `RAM[0xFF]`, `RAM[0x00]`, `RAM[0x01]` = 5A.
  - Required: `RAM[0x02]` unchanged; `done` in cycle 5.
- Edge lengths:
  - `len=0`: `done` in cycle 1, no `mem_we`.
  - `len=256` fill: all 256 bytes written, `done` in cycle 257.
- Overlap and ignored start:
  - Preload `RAM[0x20..0x22]=11,22,33`.
  - Copy `src=0x20`, `dst=0x21`, `len=2`.
  - Required: `RAM[0x21..0x22]=11,11`.
  - Pulse `start` mid-transfer; required: no effect and only one `done`.
- Reset mid-copy:
  - Start a `len=8` copy.
  - Assert `rst=0` in cycle 5.
  - Required: only the first 2 destination bytes written, no `done`, IDLE afterwards.
  - A new start then runs normally.
